// File: rtl/and_input_collector_pkg.sv
// Shared types and constants for the AND-reduction front end.
// Package and_pkg: collector FSM states, default width, clog2 helper.
package and_pkg;

  localparam int AND_N = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } collect_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/and_collect_timer.sv
// Idle-cycle counter: counts enabled cycles without a clear,
// asserts expire_o on the TIMEOUT-th consecutive idle cycle.
module and_collect_timer
  import and_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int TW = clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire_o = enable_i & ~clear_i &
                    (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i)
      cnt_d = expire_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/and_input_collector.sv
// Serial-to-parallel frame collector feeding the N-input AND.
// Optional partial-frame timeout under macro AND_COLLECT_TIMEOUT_EN.
module and_input_collector
  import and_pkg::*;
#(
  parameter int N       = AND_N,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_i,
  input  logic         sof_i,
  input  logic         bit_valid_i,
  output logic         bit_ready_o,
  output logic [N-1:0] frame_o,
  output logic         frame_valid_o,
  input  logic         frame_ready_i,
  output logic         resync_o,
  output logic         timeout_o
);

  localparam int CW = clog2(N);

  if (N < 2) begin : g_bad_n
    $error("and_input_collector: N must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("and_input_collector: TIMEOUT must be >= 1");
  end

  collect_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   frame_q, frame_d;
  logic           resync_q, resync_d;
  logic           tmo_q, tmo_d;
  logic           accept;
  logic           expire;

  assign bit_ready_o   = ~rst & (state_q != HOLD);
  assign accept        = bit_valid_i & bit_ready_o;
  assign frame_o       = frame_q;
  assign frame_valid_o = (state_q == HOLD);
  assign resync_o      = resync_q;
  assign timeout_o     = tmo_q;

`ifdef AND_COLLECT_TIMEOUT_EN
  and_collect_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .enable_i (state_q == COLLECT),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    resync_d = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d    = '0;
          frame_d[0] = bit_i;
          cnt_d      = CW'(1);
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (sof_i) begin
            // restart: drop stale upper bits of the partial frame
            frame_d    = '0;
            frame_d[0] = bit_i;
            cnt_d      = CW'(1);
            resync_d   = 1'b1;
          end else begin
            frame_d[cnt_q] = bit_i;
            if (cnt_q == CW'(N - 1)) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (expire) begin
          frame_d = '0;
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (frame_ready_i) begin
          frame_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      frame_q  <= '0;
      resync_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      resync_q <= resync_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule
